// File: rtl/rf_wport_arbiter_if.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////////////
// rf_wport_arbiter_if : WB / LU request bundle plus the register-file write port
// Revision 1.0
////////////////////////////////////////////////////////////////////////////////
interface rf_wport_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              wb_rd_write;
  logic [REG_AW-1:0] wb_rd_addr;
  logic [XLEN-1:0]   wb_rd_wdata;
  logic              wb_stall;

  logic              lu_valid;
  logic              lu_ready;
  logic [REG_AW-1:0] lu_rd_addr;
  logic [XLEN-1:0]   lu_rd_wdata;

  logic              rf_write;
  logic [REG_AW-1:0] rf_addr;
  logic [XLEN-1:0]   rf_wdata;

  // Requesters and register file side
  modport master (
    output wb_rd_write, wb_rd_addr, wb_rd_wdata,
    input  wb_stall,
    output lu_valid, lu_rd_addr, lu_rd_wdata,
    input  lu_ready,
    input  rf_write, rf_addr, rf_wdata
  );

  // Arbiter side
  modport slave (
    input  wb_rd_write, wb_rd_addr, wb_rd_wdata,
    output wb_stall,
    input  lu_valid, lu_rd_addr, lu_rd_wdata,
    output lu_ready,
    output rf_write, rf_addr, rf_wdata
  );
endinterface
`default_nettype wire

// File: rtl/rf_wport_arbiter.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////////////
// rf_wport_arbiter : shares the RF write port between WB (priority) and a queued LU
// Revision 1.0
////////////////////////////////////////////////////////////////////////////////
module rf_wport_arbiter #(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int BUF_DEPTH  = 2,
  parameter int STARVE_MAX = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_b,
  rf_wport_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [CNT_W-1:0] c_full       = CNT_W'(BUF_DEPTH);
  localparam logic [STV_W-1:0] c_starve_sat = STV_W'(STARVE_MAX);

  logic [REG_AW-1:0] r_buf_addr [BUF_DEPTH];
  logic [XLEN-1:0]   r_buf_data [BUF_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [STV_W-1:0]  r_starve_cnt;

  logic              w_wb_req;
  logic              w_lu_pend;
  logic              w_lu_grant;
  logic              w_lu_ready;
  logic              w_push;
  logic              w_pop;
  logic [REG_AW-1:0] w_head_addr;
  logic [XLEN-1:0]   w_head_data;
  logic              w_rf_write;
  logic [REG_AW-1:0] w_rf_addr;
  logic [XLEN-1:0]   w_rf_wdata;
  logic              w_wb_stall;

  assign w_head_addr = r_buf_addr[r_rd_ptr];
  assign w_head_data = r_buf_data[r_rd_ptr];

  // x0 writes from WB are architecturally dead: they neither use the port nor stall
  always_comb begin
    w_wb_req   = bus.wb_rd_write && (bus.wb_rd_addr != '0);
    w_lu_pend  = (r_count != '0);
    w_lu_grant = w_lu_pend && (!w_wb_req || (r_starve_cnt == c_starve_sat));
    w_lu_ready = rst_b && (r_count != c_full);
    w_push     = bus.lu_valid && w_lu_ready;
    w_pop      = w_lu_grant;
  end

  always_comb begin
    w_rf_write = 1'b0;
    w_rf_addr  = bus.wb_rd_addr;
    w_rf_wdata = bus.wb_rd_wdata;
    w_wb_stall = 1'b0;
    if (w_lu_grant) begin
      w_rf_write = (w_head_addr != '0);
      w_rf_addr  = w_head_addr;
      w_rf_wdata = w_head_data;
      w_wb_stall = w_wb_req;
    end else begin
      w_rf_write = w_wb_req;
    end
    // Reset must mask the port even though state only clears at the next edge
    if (!rst_b) begin
      w_rf_write = 1'b0;
      w_wb_stall = 1'b0;
    end
  end

  assign bus.rf_write = w_rf_write;
  assign bus.rf_addr  = w_rf_addr;
  assign bus.rf_wdata = w_rf_wdata;
  assign bus.wb_stall = w_wb_stall;
  assign bus.lu_ready = w_lu_ready;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf_addr[i] <= '0;
        r_buf_data[i] <= '0;
      end
    end else if (w_push) begin
      r_buf_addr[r_wr_ptr] <= bus.lu_rd_addr;
      r_buf_data[r_wr_ptr] <= bus.lu_rd_wdata;
    end
  end

  // Depth is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_starve_cnt <= '0;
    end else if (w_lu_grant || !w_lu_pend) begin
      r_starve_cnt <= '0;
    end else if (w_wb_req && (r_starve_cnt != c_starve_sat)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_wport_arbiter.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////////////
// tb_rf_wport_arbiter : directed checks of WB/LU write-port sharing
// Revision 1.0
////////////////////////////////////////////////////////////////////////////////
module tb_rf_wport_arbiter;

  logic clk;
  logic rst_b;
  int   checks;
  int   errors;

  rf_wport_arbiter_if #(.XLEN(32), .REG_AW(5)) bus ();

  rf_wport_arbiter #(
    .XLEN(32), .REG_AW(5), .BUF_DEPTH(2), .STARVE_MAX(4)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Port check; address/data only matter when a write is expected
  task automatic chk_port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".rf_write"}, 64'(bus.rf_write), 64'(we));
    if (we) begin
      chk({tag, ".rf_addr"},  64'(bus.rf_addr),  64'(a));
      chk({tag, ".rf_wdata"}, 64'(bus.rf_wdata), 64'(d));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.wb_rd_write = en;
    bus.wb_rd_addr  = a;
    bus.wb_rd_wdata = d;
  endtask

  task automatic lu(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.lu_valid    = v;
    bus.lu_rd_addr  = a;
    bus.lu_rd_wdata = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_b  = 1'b0;
    wb(1'b1, 5'd5, 32'hDEAD);
    lu(1'b1, 5'd6, 32'hBEEF);

    // Reset held: outputs masked regardless of requests
    tick(); #3;
    chk("rst.rf_write", 64'(bus.rf_write), 64'd0);
    chk("rst.wb_stall", 64'(bus.wb_stall), 64'd0);
    chk("rst.lu_ready", 64'(bus.lu_ready), 64'd0);
    tick();

    // WB only
    rst_b = 1'b1;
    wb(1'b1, 5'd5, 32'hA5);
    lu(1'b0, 5'd0, 32'h0);
    #3;
    chk_port("wbonly", 1'b1, 5'd5, 32'hA5);
    chk("wbonly.stall", 64'(bus.wb_stall), 64'd0);
    chk("wbonly.lu_ready", 64'(bus.lu_ready), 64'd1);

    // LU only: one-cycle latency through the FIFO
    tick();
    wb(1'b0, 5'd0, 32'h0);
    lu(1'b1, 5'd7, 32'h1234);
    #3;
    chk("luonly.c0.rf_write", 64'(bus.rf_write), 64'd0);
    chk("luonly.c0.lu_ready", 64'(bus.lu_ready), 64'd1);
    tick();
    lu(1'b0, 5'd0, 32'h0);
    #3;
    chk_port("luonly.c1", 1'b1, 5'd7, 32'h1234);
    chk("luonly.c1.lu_ready", 64'(bus.lu_ready), 64'd1);
    tick(); #3;
    chk("luonly.c2.rf_write", 64'(bus.rf_write), 64'd0);

    // Starvation: WB wins four cycles, fifth forces LU and stalls WB once
    tick();
    wb(1'b1, 5'd9, 32'h90);
    lu(1'b1, 5'd3, 32'h33);
    #3;
    chk_port("starve.push", 1'b1, 5'd9, 32'h90);
    for (int i = 1; i <= 4; i++) begin
      tick();
      lu(1'b0, 5'd0, 32'h0);
      wb(1'b1, 5'd9, 32'h90 + 32'(i));
      #3;
      chk_port($sformatf("starve.wbwin%0d", i), 1'b1, 5'd9, 32'h90 + 32'(i));
      chk($sformatf("starve.wbwin%0d.stall", i), 64'(bus.wb_stall), 64'd0);
    end
    tick();
    wb(1'b1, 5'd9, 32'h95);
    #3;
    chk_port("starve.force", 1'b1, 5'd3, 32'h33);
    chk("starve.force.stall", 64'(bus.wb_stall), 64'd1);
    tick(); #3;
    chk_port("starve.retry", 1'b1, 5'd9, 32'h95);
    chk("starve.retry.stall", 64'(bus.wb_stall), 64'd0);

    // Fill: three LU pushes while WB is continuously busy
    tick();
    wb(1'b1, 5'd10, 32'hA0);
    lu(1'b1, 5'd11, 32'h111);
    #3;
    chk("fill.c0.lu_ready", 64'(bus.lu_ready), 64'd1);
    chk_port("fill.c0", 1'b1, 5'd10, 32'hA0);
    tick();
    wb(1'b1, 5'd10, 32'hA1);
    lu(1'b1, 5'd12, 32'h222);
    #3;
    chk("fill.c1.lu_ready", 64'(bus.lu_ready), 64'd1);
    chk_port("fill.c1", 1'b1, 5'd10, 32'hA1);
    tick();
    wb(1'b1, 5'd10, 32'hA2);
    lu(1'b1, 5'd13, 32'h333);
    #3;
    chk("fill.c2.lu_ready", 64'(bus.lu_ready), 64'd0);
    chk_port("fill.c2", 1'b1, 5'd10, 32'hA2);
    for (int i = 3; i <= 4; i++) begin
      tick();
      wb(1'b1, 5'd10, 32'hA0 + 32'(i));
      #3;
      chk($sformatf("fill.c%0d.lu_ready", i), 64'(bus.lu_ready), 64'd0);
      chk_port($sformatf("fill.c%0d", i), 1'b1, 5'd10, 32'hA0 + 32'(i));
    end
    tick();
    wb(1'b1, 5'd10, 32'hA5);
    #3;
    chk_port("fill.c5.force", 1'b1, 5'd11, 32'h111);
    chk("fill.c5.stall", 64'(bus.wb_stall), 64'd1);
    chk("fill.c5.lu_ready", 64'(bus.lu_ready), 64'd0);
    tick(); #3;
    chk_port("fill.c6.retry", 1'b1, 5'd10, 32'hA5);
    chk("fill.c6.stall", 64'(bus.wb_stall), 64'd0);
    chk("fill.c6.lu_ready", 64'(bus.lu_ready), 64'd1);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    lu(1'b0, 5'd0, 32'h0);
    #3;
    chk_port("fill.c7", 1'b1, 5'd12, 32'h222);
    tick(); #3;
    chk_port("fill.c8", 1'b1, 5'd13, 32'h333);
    tick(); #3;
    chk("fill.c9.rf_write", 64'(bus.rf_write), 64'd0);

    // x0 handling on both sides
    lu(1'b1, 5'd4, 32'h44);
    #3;
    chk("x0.d0.rf_write", 64'(bus.rf_write), 64'd0);
    tick();
    wb(1'b1, 5'd0, 32'hFF);
    lu(1'b1, 5'd0, 32'h55);
    #3;
    chk_port("x0.d1", 1'b1, 5'd4, 32'h44);
    chk("x0.d1.stall", 64'(bus.wb_stall), 64'd0);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    lu(1'b0, 5'd0, 32'h0);
    #3;
    chk("x0.d2.rf_write", 64'(bus.rf_write), 64'd0);
    chk("x0.d2.stall", 64'(bus.wb_stall), 64'd0);
    tick(); #3;
    chk("x0.d3.rf_write", 64'(bus.rf_write), 64'd0);
    chk("x0.d3.lu_ready", 64'(bus.lu_ready), 64'd1);

    // Reset with two entries queued
    tick();
    wb(1'b1, 5'd8, 32'h80);
    lu(1'b1, 5'd20, 32'h200);
    tick();
    lu(1'b1, 5'd21, 32'h210);
    tick();
    rst_b = 1'b0;
    #3;
    chk("mrst.rf_write", 64'(bus.rf_write), 64'd0);
    chk("mrst.lu_ready", 64'(bus.lu_ready), 64'd0);
    chk("mrst.stall", 64'(bus.wb_stall), 64'd0);
    tick();
    rst_b = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    lu(1'b0, 5'd0, 32'h0);
    #3;
    chk("mrst.after.rf_write", 64'(bus.rf_write), 64'd0);
    chk("mrst.after.lu_ready", 64'(bus.lu_ready), 64'd1);
    tick(); #3;
    chk("mrst.after2.rf_write", 64'(bus.rf_write), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
